load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side load/store unit sitting directly upstream of the data-memory controller (cache plus backing memory). It accepts one load or store per handshake from the MEM stage and decodes RISC-V `funct3` into byte lanes. It drives the controller's address/data/strobe/byte-select inputs and holds the request stable until `memReady`. It sign- or zero-extends returned load data, and splits misaligned accesses into two aligned word beats.

## Interface
- `MISALIGN_SPLIT`, 1, 1: misaligned accesses are split into two beats; 0: misaligned accesses fault with no memory access.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low; state cleared on a rising edge where `reset==0`.
- `req_valid` in 1: MEM stage presents a request.
- `req_ready` out 1: high only in IDLE; request accepted on an edge with `req_valid && req_ready`.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only for BU/HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_done` out 1: one-cycle pulse, access complete.
- `resp_fault` out 1: valid with `resp_done`; illegal funct3 or unsplit misalignment.
- `resp_rdata` out 32: extended load data; registered, holds until the next `resp_done`.
- `mem_address` out 32: word-aligned byte address, `[1:0]==0`.
- `mem_datain` out 32: lane-aligned store data.
- `mem_wen` out 1: write strobe.
- `mem_ren` out 1: read strobe.
- `mem_byte_select_vector` out 4: bit i enables bits `[8i+7:8i]`.
- `mem_memReady` in 1: beat completes on an edge where a strobe is high and this is 1.
- `mem_dataout` in 32: read word, sampled on the completing edge.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- **IDLE:** `req_ready=1`. On accept, latch the request, then:
  - Illegal funct3 (011, 110, 111; or 100/101 with store) → RESP with fault, no strobes.
  - Misaligned with `MISALIGN_SPLIT=0` → RESP with fault, no strobes.
  - Otherwise → ACC0.
- **ACC0:** drive beat 0 at `{addr[31:2],2'b00}`.
  - On completion, → ACC1 if split, else → RESP.
- **ACC1:** drive beat 1 at `{addr[31:2],2'b00}+4`; wraps 0xFFFFFFFC→0x00000000.
  - On completion → RESP.
- **RESP:** `resp_done=1` for one cycle; `resp_rdata` and `resp_fault` update on entry. → IDLE.
- **Lane mask:** size mask m = 0001/0011/1111 for B/H/W.
  - Full mask = `{4'b0,m} << off`, where off = `addr[1:0]`.
  - Beat 0 select = full mask[3:0]; beat 1 select = full mask[7:4].
  - A split occurs iff full mask[7:4] ≠ 0.
- **Store data:** `mem_datain = req_wdata` rotated left by 8·off, identical on both beats.
- **Load assembly:** {beat1, beat0} shifted right by 8·off, low 8/16/32 bits taken.
  - Sign-extend for B/H; zero-extend for BU/HU.
  - Non-selected lanes of beat words are ignored.
- Request fields must not be re-sampled after accept. All `mem_*` outputs stay constant while a beat waits on `mem_memReady`.
- Outside ACC0/ACC1: `mem_wen=mem_ren=0`, `mem_byte_select_vector=0`.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_done=0`, `resp_fault=0`, `resp_rdata=0`, every `mem_*` output 0.
- Reset mid-access: IDLE on that edge; strobes low from the next cycle. The in-flight response is discarded, so no `resp_done`.
- Aligned, zero-wait case:
  - accept edge T0;
  - strobes high in cycle T1, completing at the end of T1;
  - `resp_done` in T2;
  - `req_ready` high in T3.
- Each wait cycle (`mem_memReady=0`) adds one cycle. A split access adds at least one cycle (ACC1).
- Fault path: accept T0, `resp_done`/`resp_fault` in T1.
- `req_ready` is a registered state decode; no combinational path from `req_valid`.

## Structure
- `lsu_pkg`: funct3 encodings, FSM state enum, size-mask constants.
- Sub-module `lsu_lane_align`, purely combinational, covering:
  - mask generation;
  - store rotation;
  - load extraction and extension.
- The FSM and registers live in `load_store_unit`.

## Test plan
- **Aligned LW:** addr 0x100, `mem_dataout`=0xDEADBEEF, memReady high in the first strobe cycle.
  - Expect one read beat, select 1111, address 0x100.
  - Expect `resp_rdata`=0xDEADBEEF and `resp_done` 2 cycles after accept.
- **LB / LBU:** addr 0x203, word 0x80FF_0000.
  - LB → 0xFFFFFF80 with select 1000.
  - LBU → 0x00000080.
- **SH at addr 0x102, wdata 0x0000ABCD:**
  - Expect `mem_datain`=0xABCD0000, select 1100, `mem_wen`=1.
  - Hold memReady low 3 cycles; all `mem_*` outputs stable; `resp_done` 3 cycles later than the zero-wait case.
- **Misaligned LW at 0x0FFE:**
  - Beat 0 at 0x0FFC returns 0x1122_3344, select 1100.
  - Beat 1 at 0x1000 returns 0x5566_7788, select 0011.
  - Expect `resp_rdata`=0x77881122.
  - Repeat at 0xFFFFFFFE; beat 1 address = 0x00000000.
- **Faults:** funct3=011, and LW at 0x1 with `MISALIGN_SPLIT=0`.
  - Expect no strobes, `resp_fault`=1 with `resp_done` one cycle after accept.
- **Reset mid-access:** `reset=0` while in ACC1 with memReady low.
  - Next cycle: IDLE, strobes 0, `req_ready`=1, no `resp_done`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: funct3 codes,
// FSM states, size masks and request-legality checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural-alignment check, independent of whether the access would split.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = offset[0];
      2'b10:   mis = |offset;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    logic [3:0] m;
    case (funct3[1:0])
      2'b00:   m = MASK_B;
      2'b01:   m = MASK_H;
      2'b10:   m = MASK_W;
      default: m = MASK_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: byte-select masks, store-data rotation and
// load-data extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] beat0,
  input  logic [23:0] beat1_lo,
  output logic [3:0]  lo_mask,
  output logic [3:0]  hi_mask,
  output logic        split,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [7:0]  full_mask_s;
  logic [31:0] load_word_s;

  assign full_mask_s = {4'b0000, size_mask(funct3)} << offset;
  assign lo_mask     = full_mask_s[3:0];
  assign hi_mask     = full_mask_s[7:4];
  assign split       = |full_mask_s[7:4];

  // Rotate store data into its byte lanes; both beats carry the same word.
  always_comb begin
    store_data = wdata;
    case (offset)
      2'd0:    store_data = wdata;
      2'd1:    store_data = {wdata[23:0], wdata[31:24]};
      2'd2:    store_data = {wdata[15:0], wdata[31:16]};
      2'd3:    store_data = {wdata[7:0],  wdata[31:8]};
      default: store_data = wdata;
    endcase
  end

  // Right-justify {beat1, beat0} by the byte offset, then extend.
  always_comb begin
    load_word_s = beat0;
    load_data   = 32'h0000_0000;
    case (offset)
      2'd0:    load_word_s = beat0;
      2'd1:    load_word_s = {beat1_lo[7:0],  beat0[31:8]};
      2'd2:    load_word_s = {beat1_lo[15:0], beat0[31:16]};
      2'd3:    load_word_s = {beat1_lo[23:0], beat0[31:24]};
      default: load_word_s = beat0;
    endcase
    case (funct3)
      F3_B:    load_data = {{24{load_word_s[7]}}, load_word_s[7:0]};
      F3_H:    load_data = {{16{load_word_s[15]}}, load_word_s[15:0]};
      F3_W:    load_data = load_word_s;
      F3_BU:   load_data = {24'h00_0000, load_word_s[7:0]};
      F3_HU:   load_data = {16'h0000, load_word_s[15:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: request handshake, beat sequencing toward the
// data-memory controller, and registered response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_done,
  output logic        resp_fault,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_byte_select_vector,
  input  logic        mem_memReady,
  input  logic [31:0] mem_dataout
);

  lsu_state_t  state_r, state_next_s;
  logic        is_store_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r, wdata_r, beat0_r;
  logic        resp_fault_r;
  logic [31:0] resp_rdata_r;

  logic        accept_s, req_fault_s, in_access_s, beat_done_s, split_s;
  logic [3:0]  lo_mask_s, hi_mask_s;
  logic [31:0] store_data_s, load_data_s, beat0_word_s, word_base_s;

  assign accept_s     = req_valid & (state_r == ST_IDLE);
  assign req_fault_s  = ~funct3_legal(req_is_store, req_funct3)
                      | (~MISALIGN_SPLIT & is_misaligned(req_funct3, req_addr[1:0]));
  assign in_access_s  = (state_r == ST_ACC0) | (state_r == ST_ACC1);
  assign beat_done_s  = in_access_s & mem_memReady;
  // On a single-beat completion beat 0 is still on the bus, not yet in beat0_r.
  assign beat0_word_s = (state_r == ST_ACC0) ? mem_dataout : beat0_r;
  assign word_base_s  = {addr_r[31:2], 2'b00};

  lsu_lane_align u_lane_align (
    .funct3     (funct3_r),
    .offset     (addr_r[1:0]),
    .wdata      (wdata_r),
    .beat0      (beat0_word_s),
    .beat1_lo   (mem_dataout[23:0]),
    .lo_mask    (lo_mask_s),
    .hi_mask    (hi_mask_s),
    .split      (split_s),
    .store_data (store_data_s),
    .load_data  (load_data_s)
  );

  // State, latched request, first-beat capture and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      is_store_r   <= 1'b0;
      funct3_r     <= 3'b000;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      beat0_r      <= 32'h0000_0000;
      resp_fault_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        is_store_r <= req_is_store;
        funct3_r   <= req_funct3;
        addr_r     <= req_addr;
        wdata_r    <= req_wdata;
      end
      if ((state_r == ST_ACC0) && mem_memReady) begin
        beat0_r <= mem_dataout;
      end
      if ((state_next_s == ST_RESP) && (state_r != ST_RESP)) begin
        resp_fault_r <= (state_r == ST_IDLE);
        resp_rdata_r <= ((state_r == ST_IDLE) || is_store_r) ? 32'h0000_0000 : load_data_s;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: state_next_s = accept_s ? (req_fault_s ? ST_RESP : ST_ACC0) : ST_IDLE;
      ST_ACC0: state_next_s = beat_done_s ? (split_s ? ST_ACC1 : ST_RESP) : ST_ACC0;
      ST_ACC1: state_next_s = beat_done_s ? ST_RESP : ST_ACC1;
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Memory-side outputs decoded from registered state and latched request only.
  always_comb begin
    mem_address            = 32'h0000_0000;
    mem_datain             = 32'h0000_0000;
    mem_wen                = 1'b0;
    mem_ren                = 1'b0;
    mem_byte_select_vector = 4'b0000;
    case (state_r)
      ST_ACC0: begin
        mem_address            = word_base_s;
        mem_datain             = is_store_r ? store_data_s : 32'h0000_0000;
        mem_wen                = is_store_r;
        mem_ren                = ~is_store_r;
        mem_byte_select_vector = lo_mask_s;
      end
      ST_ACC1: begin
        mem_address            = word_base_s + 32'd4;
        mem_datain             = is_store_r ? store_data_s : 32'h0000_0000;
        mem_wen                = is_store_r;
        mem_ren                = ~is_store_r;
        mem_byte_select_vector = hi_mask_s;
      end
      default: begin
        mem_address            = 32'h0000_0000;
        mem_datain             = 32'h0000_0000;
        mem_wen                = 1'b0;
        mem_ren                = 1'b0;
        mem_byte_select_vector = 4'b0000;
      end
    endcase
  end

  assign req_ready  = (state_r == ST_IDLE);
  assign resp_done  = (state_r == ST_RESP);
  assign resp_fault = resp_fault_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: aligned, sub-word,
// wait-stated, split and faulting accesses plus reset during an access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid_b, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_memReady;
  logic [31:0] mem_dataout;

  logic        req_ready, resp_done, resp_fault, mem_wen, mem_ren;
  logic [31:0] resp_rdata, mem_address, mem_datain;
  logic [3:0]  mem_byte_select_vector;

  logic        req_ready_b, resp_done_b, resp_fault_b, mem_wen_b, mem_ren_b;
  logic [31:0] resp_rdata_b, mem_address_b, mem_datain_b;
  logic [3:0]  mem_byte_select_vector_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_fault(resp_fault), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_datain(mem_datain), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_byte_select_vector(mem_byte_select_vector),
    .mem_memReady(mem_memReady), .mem_dataout(mem_dataout)
  );

  load_store_unit #(.MISALIGN_SPLIT(1'b0)) dut_nosplit (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_done(resp_done_b), .resp_fault(resp_fault_b), .resp_rdata(resp_rdata_b),
    .mem_address(mem_address_b), .mem_datain(mem_datain_b), .mem_wen(mem_wen_b),
    .mem_ren(mem_ren_b), .mem_byte_select_vector(mem_byte_select_vector_b),
    .mem_memReady(mem_memReady), .mem_dataout(mem_dataout)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, serve its beats (waits only on beat 0), check response.
  task automatic run_access(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                            input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                            input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                            input logic [31:0] exp_din, input logic [31:0] exp_rd);
    int nbeats;
    int nwait;
    nbeats = (s1 != 4'b0000) ? 2 : 1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    step();
    req_valid    = 1'b0;
    req_is_store = ~st;
    req_funct3   = 3'b111;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'h5A5A_5A5A;
    for (int b = 0; b < nbeats; b++) begin
      nwait = (b == 0) ? waits : 0;
      for (int w = 0; w <= nwait; w++) begin
        check({tag, ".ren"},  {31'd0, mem_ren}, {31'd0, ~st});
        check({tag, ".wen"},  {31'd0, mem_wen}, {31'd0, st});
        check({tag, ".addr"}, mem_address, (b == 0) ? a0 : a1);
        check({tag, ".sel"},  {28'd0, mem_byte_select_vector}, {28'd0, (b == 0) ? s0 : s1});
        if (st) check({tag, ".din"}, mem_datain, exp_din);
        check({tag, ".busy_done"},  {31'd0, resp_done}, 32'd0);
        check({tag, ".busy_ready"}, {31'd0, req_ready}, 32'd0);
        mem_memReady = (w == nwait);
        mem_dataout  = (w == nwait) ? ((b == 0) ? d0 : d1) : 32'hBAD0_BAD0;
        step();
      end
    end
    mem_memReady = 1'b0;
    mem_dataout  = 32'h0000_0000;
    check({tag, ".done"},  {31'd0, resp_done},  32'd1);
    check({tag, ".fault"}, {31'd0, resp_fault}, 32'd0);
    if (!st) check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".strobe_off"}, {30'd0, mem_ren, mem_wen}, 32'd0);
    step();
    check({tag, ".ready"},   {31'd0, req_ready}, 32'd1);
    check({tag, ".done_lo"}, {31'd0, resp_done}, 32'd0);
    if (!st) check({tag, ".rdata_hold"}, resp_rdata, exp_rd);
  endtask

  task automatic run_fault(input string tag, input logic use_b, input logic st,
                           input logic [2:0] f3, input logic [31:0] addr);
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = 32'h1234_5678;
    req_valid    = ~use_b;
    req_valid_b  = use_b;
    step();
    req_valid    = 1'b0;
    req_valid_b  = 1'b0;
    check({tag, ".done"},  {31'd0, use_b ? resp_done_b : resp_done}, 32'd1);
    check({tag, ".fault"}, {31'd0, use_b ? resp_fault_b : resp_fault}, 32'd1);
    check({tag, ".strobes"}, {30'd0, use_b ? {mem_ren_b, mem_wen_b} : {mem_ren, mem_wen}}, 32'd0);
    check({tag, ".sel"}, {28'd0, use_b ? mem_byte_select_vector_b : mem_byte_select_vector}, 32'd0);
    step();
    check({tag, ".ready"},   {31'd0, use_b ? req_ready_b : req_ready}, 32'd1);
    check({tag, ".done_lo"}, {31'd0, use_b ? resp_done_b : resp_done}, 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_valid_b  = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0000_0000;
    req_wdata    = 32'h0000_0000;
    mem_memReady = 1'b0;
    mem_dataout  = 32'h0000_0000;
    step();
    step();
    check("rst.ready", {31'd0, req_ready},  32'd1);
    check("rst.done",  {31'd0, resp_done},  32'd0);
    check("rst.fault", {31'd0, resp_fault}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.addr",  mem_address, 32'd0);
    check("rst.din",   mem_datain, 32'd0);
    check("rst.strb",  {26'd0, mem_byte_select_vector, mem_ren, mem_wen}, 32'd0);
    reset = 1'b1;
    step();

    //          tag      st    f3      addr           wdata          w  a0             s0       d0             a1             s1       d1             din            rdata
    run_access("lw",    1'b0, 3'b010, 32'h0000_0100, 32'h0,         0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0,         4'b0000, 32'h0,         32'h0,         32'hDEAD_BEEF);
    run_access("lb",    1'b0, 3'b000, 32'h0000_0203, 32'h0,         0, 32'h0000_0200, 4'b1000, 32'h80FF_0000, 32'h0,         4'b0000, 32'h0,         32'h0,         32'hFFFF_FF80);
    run_access("lbu",   1'b0, 3'b100, 32'h0000_0203, 32'h0,         0, 32'h0000_0200, 4'b1000, 32'h80FF_0000, 32'h0,         4'b0000, 32'h0,         32'h0,         32'h0000_0080);
    run_access("lh",    1'b0, 3'b001, 32'h0000_0002, 32'h0,         0, 32'h0000_0000, 4'b1100, 32'h8001_1234, 32'h0,         4'b0000, 32'h0,         32'h0,         32'hFFFF_8001);
    run_access("lhu",   1'b0, 3'b101, 32'h0000_0002, 32'h0,         0, 32'h0000_0000, 4'b1100, 32'h8001_1234, 32'h0,         4'b0000, 32'h0,         32'h0,         32'h0000_8001);
    run_access("sh_w3", 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 3, 32'h0000_0100, 4'b1100, 32'h0,         32'h0,         4'b0000, 32'h0,         32'hABCD_0000, 32'h0);
    run_access("sb",    1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 0, 32'h0000_0000, 4'b0010, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0000_A500, 32'h0);
    run_access("lw_spl",1'b0, 3'b010, 32'h0000_0FFE, 32'h0,         0, 32'h0000_0FFC, 4'b1100, 32'h1122_3344, 32'h0000_1000, 4'b0011, 32'h5566_7788, 32'h0,         32'h7788_1122);
    run_access("lw_wrp",1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,         1, 32'hFFFF_FFFC, 4'b1100, 32'h1122_3344, 32'h0000_0000, 4'b0011, 32'h5566_7788, 32'h0,         32'h7788_1122);
    run_access("sw_spl",1'b1, 3'b010, 32'h0000_0003, 32'h1122_3344, 0, 32'h0000_0000, 4'b1000, 32'h0,         32'h0000_0004, 4'b0111, 32'h0,         32'h4411_2233, 32'h0);

    run_fault("f3_011",   1'b0, 1'b0, 3'b011, 32'h0000_0100);
    run_fault("sbu",      1'b0, 1'b1, 3'b100, 32'h0000_0100);
    run_fault("nosplit",  1'b1, 1'b0, 3'b010, 32'h0000_0001);

    // Reset while beat 1 of a split load is stalled.
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h0000_0FFE;
    req_valid    = 1'b1;
    step();
    req_valid    = 1'b0;
    mem_memReady = 1'b1;
    mem_dataout  = 32'h1122_3344;
    step();
    mem_memReady = 1'b0;
    check("mid.acc1_ren",  {31'd0, mem_ren}, 32'd1);
    check("mid.acc1_addr", mem_address, 32'h0000_1000);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid.strobes", {30'd0, mem_ren, mem_wen}, 32'd0);
    check("mid.sel",     {28'd0, mem_byte_select_vector}, 32'd0);
    check("mid.ready",   {31'd0, req_ready}, 32'd1);
    check("mid.done",    {31'd0, resp_done}, 32'd0);
    step();
    check("mid.done2",   {31'd0, resp_done}, 32'd0);

    run_access("lw_post",1'b0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D, 32'h0,         4'b0000, 32'h0,         32'h0,         32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
